// File: rtl/tlc_pkg.sv
// Shared encodings for the junction phase scheduler: lamp codes, controller
// states and approach indices.
package tlc_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } tlc_state_t;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    localparam logic [1:0] L2R = 2'd0;
    localparam logic [1:0] R2L = 2'd1;
    localparam logic [1:0] L2D = 2'd2;
    localparam logic [1:0] D2R = 2'd3;

    function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational 4-way round-robin picker: first set pending bit searching
// circularly from the approach after last.
module tlc_rr_pick
    import tlc_pkg::*;
(
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] start_s;
    logic [7:0] dbl_s;
    logic [3:0] rot_s;
    logic [1:0] offs_s;

    // Rotate the request vector so bit 0 is the approach after last, then take the lowest set bit.
    always_comb begin
        start_s = last + 2'd1;
        dbl_s   = {pending, pending};
        rot_s   = dbl_s[start_s +: 4];
        if (rot_s[0]) begin
            offs_s = 2'd0;
        end else if (rot_s[1]) begin
            offs_s = 2'd1;
        end else if (rot_s[2]) begin
            offs_s = 2'd2;
        end else begin
            offs_s = 2'd3;
        end
        grant = start_s + offs_s;
        valid = |pending;
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven phase scheduler for a four-approach junction with min/max
// green, yellow and all-red timing plus emergency preemption.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int TMIN_G = 3,
    parameter int TMAX_G = 6,
    parameter int TY     = 2,
    parameter int TAR    = 1,
    parameter int CW     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       preempt,
    input  logic [1:0] preempt_dir,
    output logic [2:0] lamp_l2r,
    output logic [2:0] lamp_r2l,
    output logic [2:0] lamp_l2d,
    output logic [2:0] lamp_d2r,
    output logic [1:0] phase,
    output logic [1:0] state,
    output logic [3:0] pending
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] TMIN_M1  = CW'(TMIN_G - 1);
    localparam logic [CW-1:0] TMAX_M1  = CW'(TMAX_G - 1);
    localparam logic [CW-1:0] TY_M1    = CW'(TY - 1);
    localparam logic [CW-1:0] TAR_M1   = CW'(TAR - 1);

    tlc_state_t    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s, cnt_sat_s;
    logic [1:0]    phase_r, phase_s;
    logic [3:0]    pending_r, pending_s;
    logic          enter_green_s;
    logic          other_s;
    logic [3:0]    green_mask_s, clr_mask_s;
    logic [1:0]    pick_grant_s;
    logic          pick_valid_s;
    logic [2:0]    active_code_s;
    logic [3:0][2:0] lamp_s;

    tlc_rr_pick u_pick (
        .pending (pending_r),
        .last    (phase_r),
        .grant   (pick_grant_s),
        .valid   (pick_valid_s)
    );

    // Demand from approaches other than the one currently holding the pointer.
    always_comb begin
        other_s = |(pending_r & ~dir_onehot(phase_r));
        if (cnt_r >= TMAX_M1) begin
            cnt_sat_s = cnt_r;
        end else begin
            cnt_sat_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state and timer logic; an illegal state recovers regardless of tick.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        phase_s       = phase_r;
        enter_green_s = 1'b0;
        if (state_r != ALL_RED && state_r != GREEN && state_r != YELLOW) begin
            state_s = ALL_RED;
            cnt_s   = CNT_ZERO;
        end else if (tick) begin
            case (state_r)
                ALL_RED: begin
                    if (cnt_r != TAR_M1) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else if (preempt) begin
                        state_s       = GREEN;
                        phase_s       = preempt_dir;
                        cnt_s         = CNT_ZERO;
                        enter_green_s = 1'b1;
                    end else if (pick_valid_s) begin
                        state_s       = GREEN;
                        phase_s       = pick_grant_s;
                        cnt_s         = CNT_ZERO;
                        enter_green_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                GREEN: begin
                    if (preempt && (preempt_dir != phase_r)) begin
                        state_s = YELLOW;
                        cnt_s   = CNT_ZERO;
                    end else if (preempt) begin
                        cnt_s = cnt_sat_s;
                    end else if (other_s && ((cnt_r == TMAX_M1) ||
                                 ((cnt_r >= TMIN_M1) && !req[phase_r]))) begin
                        state_s = YELLOW;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_sat_s;
                    end
                end
                YELLOW: begin
                    if (cnt_r != TY_M1) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        state_s = ALL_RED;
                        cnt_s   = CNT_ZERO;
                    end
                end
                default: begin
                    state_s = ALL_RED;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Request latch: the green approach ignores its own sensor, and entering green clears its bit.
    always_comb begin
        if (state_r == GREEN) begin
            green_mask_s = dir_onehot(phase_r);
        end else begin
            green_mask_s = 4'b0000;
        end
        if (enter_green_s) begin
            clr_mask_s = dir_onehot(phase_s);
        end else begin
            clr_mask_s = 4'b0000;
        end
        pending_s = (pending_r | (req & ~green_mask_s)) & ~clr_mask_s;
    end

    // Controller registers; phase resets to D2R so the first search starts at L2R.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ALL_RED;
            cnt_r     <= CNT_ZERO;
            phase_r   <= D2R;
            pending_r <= 4'b0000;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            phase_r   <= phase_s;
            pending_r <= pending_s;
        end
    end

    // Lamp decode: only the phase approach may show anything other than red.
    always_comb begin
        case (state_r)
            GREEN:   active_code_s = LAMP_G;
            YELLOW:  active_code_s = LAMP_Y;
            default: active_code_s = LAMP_R;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == phase_r) begin
                lamp_s[i] = active_code_s;
            end else begin
                lamp_s[i] = LAMP_R;
            end
        end
    end

    assign lamp_l2r = lamp_s[L2R];
    assign lamp_r2l = lamp_s[R2L];
    assign lamp_l2d = lamp_s[L2D];
    assign lamp_d2r = lamp_s[D2R];
    assign phase    = phase_r;
    assign state    = state_r;
    assign pending  = pending_r;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Scoreboard bench for tlc_phase_scheduler: directed stimulus queues the
// expected post-edge response; a negedge monitor pops and compares.
module tb_tlc_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       preempt = 1'b0;
    logic [1:0] preempt_dir = 2'd0;
    logic [2:0] lamp_l2r, lamp_r2l, lamp_l2d, lamp_d2r;
    logic [1:0] phase, state;
    logic [3:0] pending;

    tlc_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .req         (req),
        .preempt     (preempt),
        .preempt_dir (preempt_dir),
        .lamp_l2r    (lamp_l2r),
        .lamp_r2l    (lamp_r2l),
        .lamp_l2d    (lamp_l2d),
        .lamp_d2r    (lamp_d2r),
        .phase       (phase),
        .state       (state),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [1:0] ph;
        logic [3:0] pend;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cycn = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [11:0] exp_lamps;
    logic [11:0] act_lamps;

    // Lamp buses packed {d2r, l2d, r2l, l2r}; only the served approach leaves red.
    function automatic logic [11:0] lamps_for(input logic [1:0] st, input logic [1:0] ph);
        logic [11:0] v;
        v = 12'b100_100_100_100;
        if (st == 2'd1) begin
            v[ph*3 +: 3] = 3'b001;
        end else if (st == 2'd2) begin
            v[ph*3 +: 3] = 3'b010;
        end
        return v;
    endfunction

    always @(posedge clk) cycn <= cycn + 1;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cycn) begin
            mon_e     = sbq.pop_front();
            exp_lamps = lamps_for(mon_e.st, mon_e.ph);
            act_lamps = {lamp_d2r, lamp_l2d, lamp_r2l, lamp_l2r};
            n_checks++;
            if (mon_e.cyc != cycn || state !== mon_e.st || phase !== mon_e.ph ||
                pending !== mon_e.pend || act_lamps !== exp_lamps) begin
                n_fail++;
                $display("FAIL cycle%0d: state=%0d phase=%0d pending=%b lamps=%b required state=%0d phase=%0d pending=%b lamps=%b",
                         mon_e.cyc, state, phase, pending, act_lamps,
                         mon_e.st, mon_e.ph, mon_e.pend, exp_lamps);
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic p, input logic [1:0] d,
                        input logic [1:0] st, input logic [1:0] ph, input logic [3:0] pend);
        req = r;
        preempt = p;
        preempt_dir = d;
        sbq.push_back('{cycn + 1, st, ph, pend});
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n, input logic [3:0] r, input logic p, input logic [1:0] d,
                       input logic [1:0] st, input logic [1:0] ph, input logic [3:0] pend);
        for (int i = 0; i < n; i++) begin
            step(r, p, d, st, ph, pend);
        end
    endtask

    // One cycle, then rst asserted mid-cycle; the check at that cycle's negedge expects reset values.
    task automatic step_reset(input logic [3:0] r, input logic p, input logic [1:0] d);
        req = r;
        preempt = p;
        preempt_dir = d;
        sbq.push_back('{cycn + 1, 2'd0, 2'd3, 4'b0000});
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle.
        run(2, 4'b0000, 1'b0, 2'd0, 2'd0, 2'd3, 4'b0000);
        rst = 1'b0;
        run(20, 4'b0000, 1'b0, 2'd0, 2'd0, 2'd3, 4'b0000);

        // Single request on L2D: latch, grant, rest on green.
        step(4'b0100, 1'b0, 2'd0, 2'd0, 2'd3, 4'b0100);
        step(4'b0000, 1'b0, 2'd0, 2'd1, 2'd2, 4'b0000);
        run(20, 4'b0000, 1'b0, 2'd0, 2'd1, 2'd2, 4'b0000);

        // Move to L2R with its sensor held, then D2R demand forces max-out after 6 ticks.
        step(4'b0001, 1'b0, 2'd0, 2'd1, 2'd2, 4'b0001);
        run(2, 4'b0001, 1'b0, 2'd0, 2'd2, 2'd2, 4'b0001);
        step(4'b0001, 1'b0, 2'd0, 2'd0, 2'd2, 4'b0001);
        step(4'b0001, 1'b0, 2'd0, 2'd1, 2'd0, 4'b0000);
        step(4'b1001, 1'b0, 2'd0, 2'd1, 2'd0, 4'b1000);
        run(4, 4'b0001, 1'b0, 2'd0, 2'd1, 2'd0, 4'b1000);
        run(2, 4'b0000, 1'b0, 2'd0, 2'd2, 2'd0, 4'b1000);
        step(4'b0000, 1'b0, 2'd0, 2'd0, 2'd0, 4'b1000);
        step(4'b0000, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0000);
        run(2, 4'b0000, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0000);
        step_reset(4'b0000, 1'b0, 2'd0);
        run(2, 4'b0000, 1'b0, 2'd0, 2'd0, 2'd3, 4'b0000);
        rst = 1'b0;

        // Three simultaneous requests served 0, 1, 3 with gap-out at minimum green.
        step(4'b1011, 1'b0, 2'd0, 2'd0, 2'd3, 4'b1011);
        step(4'b0000, 1'b0, 2'd0, 2'd1, 2'd0, 4'b1010);
        run(2, 4'b0000, 1'b0, 2'd0, 2'd1, 2'd0, 4'b1010);
        run(2, 4'b0000, 1'b0, 2'd0, 2'd2, 2'd0, 4'b1010);
        step(4'b0000, 1'b0, 2'd0, 2'd0, 2'd0, 4'b1010);
        run(3, 4'b0000, 1'b0, 2'd0, 2'd1, 2'd1, 4'b1000);
        run(2, 4'b0000, 1'b0, 2'd0, 2'd2, 2'd1, 4'b1000);
        step(4'b0000, 1'b0, 2'd0, 2'd0, 2'd1, 4'b1000);
        run(4, 4'b0000, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0000);

        // Back to L2R, then preempt toward R2L overrides minimum green and holds past max.
        step(4'b0001, 1'b0, 2'd0, 2'd1, 2'd3, 4'b0001);
        run(2, 4'b0000, 1'b0, 2'd0, 2'd2, 2'd3, 4'b0001);
        step(4'b0000, 1'b0, 2'd0, 2'd0, 2'd3, 4'b0001);
        step(4'b0000, 1'b0, 2'd0, 2'd1, 2'd0, 4'b0000);
        run(2, 4'b0000, 1'b1, 2'd1, 2'd2, 2'd0, 4'b0000);
        step(4'b0000, 1'b1, 2'd1, 2'd0, 2'd0, 4'b0000);
        step(4'b0000, 1'b1, 2'd1, 2'd1, 2'd1, 4'b0000);
        run(10, 4'b0100, 1'b1, 2'd1, 2'd1, 2'd1, 4'b0100);
        step(4'b0000, 1'b0, 2'd0, 2'd2, 2'd1, 4'b0100);

        // Reset asserted mid-yellow.
        step_reset(4'b0000, 1'b0, 2'd0);
        run(2, 4'b0000, 1'b0, 2'd0, 2'd0, 2'd3, 4'b0000);
        rst = 1'b0;
        run(3, 4'b0000, 1'b0, 2'd0, 2'd0, 2'd3, 4'b0000);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left in scoreboard, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlc_phase_scheduler.md
Name: tlc_phase_scheduler

Overview:
Demand-driven phase scheduler for a four-approach junction (L2R, R2L/R2D, L2D, D2R). It replaces a fixed-cycle signal sequencer.
- Latches vehicle-sensor requests and grants green to one approach at a time, in round-robin order.
- Enforces minimum/maximum green, yellow and all-red clearance times.
- Supports emergency preemption.
- Drives the four 3-bit lamp buses that feed the junction signal heads.

Parameters:
TMIN_G, 3, minimum green duration in ticks (>=1)
TMAX_G, 6, maximum green duration in ticks when another approach is waiting (>=TMIN_G)
TY, 2, yellow duration in ticks (>=1)
TAR, 1, all-red clearance duration in ticks (>=1)
CW, 4, phase-timer width; must hold TMAX_G-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  timebase enable; all timers and state advance only on clk edges where tick=1
req  in  4  sensor level per approach; bit 0=L2R, 1=R2L/R2D, 2=L2D, 3=D2R
preempt  in  1  emergency preemption request (level)
preempt_dir  in  2  approach index to be served under preemption
lamp_l2r  out  3  lamp code: 001 green, 010 yellow, 100 red
lamp_r2l  out  3  lamp code, same encoding
lamp_l2d  out  3  lamp code, same encoding
lamp_d2r  out  3  lamp code, same encoding
phase  out  2  index of the current or last granted approach
state  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW
pending  out  4  latched outstanding requests

Behaviour:
- Reset (async) values:
  - state=ALL_RED, cnt=0, phase=3, so the first search starts at approach 0.
  - pending=0, all lamps 100.
- pending[i]:
  - Set on any clk edge with req[i]=1, independent of tick.
  - Cleared on the edge that enters GREEN for approach i; clear wins over a simultaneous set.
  - While GREEN for approach i, req[i] does not set pending[i].
- other = OR of pending bits excluding the bit for phase.
- ALL_RED, on each tick:
  - If cnt<TAR-1: cnt++.
  - Else if preempt=1: GREEN, phase=preempt_dir, cnt=0.
  - Else if pending!=0: GREEN, phase = first set pending bit searching circularly from phase+1, cnt=0.
  - Else: remain in ALL_RED, cnt held.
- GREEN, on each tick, evaluated in this priority:
  - preempt=1 and preempt_dir!=phase -> YELLOW, cnt=0 (minimum green overridden).
  - preempt=1 and preempt_dir==phase -> hold GREEN, no maximum limit.
  - other=1 and (cnt==TMAX_G-1, or cnt>=TMIN_G-1 with req[phase]=0) -> YELLOW, cnt=0.
  - Otherwise: stay in GREEN; cnt increments and saturates at TMAX_G-1. With no other demand the approach rests on green indefinitely.
- YELLOW, on each tick:
  - cnt<TY-1: cnt++.
  - Else -> ALL_RED, cnt=0; phase is retained as the round-robin pointer.
- Resulting durations: ALL_RED >= TAR ticks, GREEN >= TMIN_G ticks (except under preemption), YELLOW exactly TY ticks.
- Lamps are combinational decodes of the registered state and phase:
  - GREEN: approach phase = 001, others 100.
  - YELLOW: approach phase = 010, others 100.
  - ALL_RED: all 100.
- Invariant: at most one lamp bus is ever not 100. Illegal state encoding (3) recovers to ALL_RED on the next clk edge, with lamps all 100.
- tick=0: no state or cnt change; pending still latches.
- Reset asserted mid-operation: lamps go to all 100 immediately (async); pending cleared.

Decomposition:
- Package tlc_pkg holds:
  - Lamp code constants (LAMP_G=001, LAMP_Y=010, LAMP_R=100).
  - State encodings ALL_RED/GREEN/YELLOW.
  - Approach index constants L2R=0, R2L=1, L2D=2, D2R=3.
- One sub-module, tlc_rr_pick: combinational 4-way round-robin picker. Inputs: pending[3:0], last pointer[1:0]. Outputs: grant index[1:0], valid.

Test Plan:
(All scenarios use default parameters, tick=1 every cycle.)
- Reset, req=0, preempt=0 for 20 cycles -> state=0, all lamps 100, pending=0 throughout.
- After reset, pulse req[2] one cycle -> pending=0100, then lamp_l2d=001 within 2 cycles; pending clears; green held for 20 cycles with no other demand.
- L2R green, req[0] held 1, pulse req[3] at green cnt=0 -> L2R green for exactly 6 ticks, then 010 for 2 ticks, all-red for 1 tick, then lamp_d2r=001.
- From ALL_RED with phase=3, set pending=1011 at once, req dropped -> greens served in order 0, 1, 3; each green lasts exactly 3 ticks (gap-out at TMIN_G).
- Green on phase 0 at cnt=0, assert preempt with preempt_dir=1 -> YELLOW on the next tick. Then 2 ticks of yellow, 1 tick of all-red, then lamp_r2l=001, held past 6 ticks while preempt=1.
- Assert rst mid-YELLOW -> same cycle all lamps 100, state=0, pending=0, phase=3.
